// File: rtl/seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_ctrl
//  Purpose  : Stage sequencer for the Y86-64 SEQ processor. Walks each
//             instruction through fetch, decode, execute, memory, write-back
//             and PC update, issuing a one-cycle enable to each stage. Owns
//             the architectural PC and status code, and stops the machine on
//             halt, invalid instruction or memory error.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    RESET_PC    PC value loaded on reset
//  Ports
//    clk, reset          clock, synchronous active-high reset
//    start               leave IDLE and begin execution at PC
//    icode, imem_error,  fetch-stage results
//    func_error, halt,
//    valC, valP
//    cnd                 execute-stage branch condition
//    valM, dmem_error    memory-stage results
//    PC                  current instruction address (to fetch)
//    f_en..w_en          one-hot stage enables
//    stat                1=AOK 2=HLT 3=ADR 4=INS
//    busy                high outside IDLE and STOP
//    perf_instr          retired-instruction count
//  Build option
//    SEQ_PERF_CNT_EN     when defined, perf_instr is a 32-bit wrapping
//                        retired-instruction counter; otherwise tied to 0
// ============================================================================
module seq_ctrl #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        imem_error,
  input  logic        func_error,
  input  logic        halt,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic        cnd,
  input  logic [63:0] valM,
  input  logic        dmem_error,
  output logic [63:0] PC,
  output logic        f_en,
  output logic        d_en,
  output logic        e_en,
  output logic        m_en,
  output logic        w_en,
  output logic [2:0]  stat,
  output logic        busy,
  output logic [31:0] perf_instr
);

  localparam logic [2:0] c_STAT_AOK = 3'd1;
  localparam logic [2:0] c_STAT_HLT = 3'd2;
  localparam logic [2:0] c_STAT_ADR = 3'd3;
  localparam logic [2:0] c_STAT_INS = 3'd4;

  localparam logic [3:0] c_ICODE_JXX  = 4'd7;
  localparam logic [3:0] c_ICODE_CALL = 4'd8;
  localparam logic [3:0] c_ICODE_RET  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_STOP      = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_pc;
  logic [63:0] w_new_pc;
  logic [2:0]  r_stat;
  logic [2:0]  w_stat_nxt;
  logic        w_f_en;
  logic        w_d_en;
  logic        w_e_en;
  logic        w_m_en;
  logic        w_w_en;

  // --------------------------------------------------------------------------
  // Next-PC selection. Stage outputs are held stable by the datapath through
  // PCUPD, so they are sampled only when the PC register actually loads.
  // --------------------------------------------------------------------------
  always_comb begin
    w_new_pc = valP;
    case (icode)
      c_ICODE_CALL: w_new_pc = valC;
      c_ICODE_JXX:  if (cnd) w_new_pc = valC;
      c_ICODE_RET:  w_new_pc = valM;
      default:      ;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, PC and status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_stat  <= c_STAT_AOK;
    end else begin
      r_state <= w_state_nxt;
      r_stat  <= w_stat_nxt;
      if (r_state == S_PCUPD) begin
        r_pc <= w_new_pc;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state, status update and stage enables
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_stat_nxt  = r_stat;
    w_f_en      = 1'b0;
    w_d_en      = 1'b0;
    w_e_en      = 1'b0;
    w_m_en      = 1'b0;
    w_w_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_f_en = 1'b1;
        // Address fault outranks an illegal opcode, which outranks halt.
        if (imem_error) begin
          w_stat_nxt  = c_STAT_ADR;
          w_state_nxt = S_STOP;
        end else if (func_error) begin
          w_stat_nxt  = c_STAT_INS;
          w_state_nxt = S_STOP;
        end else if (halt) begin
          w_stat_nxt  = c_STAT_HLT;
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        w_d_en      = 1'b1;
        w_state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        w_e_en      = 1'b1;
        w_state_nxt = S_MEMORY;
      end
      S_MEMORY: begin
        w_m_en = 1'b1;
        // A data fault skips write-back so no register is corrupted.
        if (dmem_error) begin
          w_stat_nxt  = c_STAT_ADR;
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        w_w_en      = 1'b1;
        w_state_nxt = S_PCUPD;
      end
      S_PCUPD: begin
        w_state_nxt = S_FETCH;
      end
      S_STOP: begin
        w_state_nxt = S_STOP;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Retired-instruction counter: one count per completed PC update, so a
  // halting or faulting instruction never reaches it.
  // --------------------------------------------------------------------------
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_perf_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_cnt <= 32'd0;
    end else if (r_state == S_PCUPD) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign perf_instr = r_perf_cnt;
`else
  assign perf_instr = 32'd0;
`endif

  assign PC   = r_pc;
  assign stat = r_stat;
  assign f_en = w_f_en;
  assign d_en = w_d_en;
  assign e_en = w_e_en;
  assign m_en = w_m_en;
  assign w_en = w_w_en;
  assign busy = (r_state != S_IDLE) && (r_state != S_STOP);

endmodule
`default_nettype wire

// File: tb/tb_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_ctrl
//  Purpose  : Self-checking bench for seq_ctrl. The bench plays the fetch,
//             execute and memory units, feeding one instruction per fetch.
//             A reference model computes the architectural outcome of each
//             instruction (next PC, status, retired count, cycles until the
//             next observable event) and queues it; an independent monitor
//             pops and compares at every fetch and at every stop.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'd0;
  logic        imem_error = 1'b0;
  logic        func_error = 1'b0;
  logic        halt = 1'b0;
  logic [63:0] valC = 64'd0;
  logic [63:0] valP = 64'd0;
  logic        cnd = 1'b0;
  logic [63:0] valM = 64'd0;
  logic        dmem_error = 1'b0;
  logic [63:0] PC;
  logic        f_en, d_en, e_en, m_en, w_en;
  logic [2:0]  stat;
  logic        busy;
  logic [31:0] perf_instr;

`ifdef SEQ_PERF_CNT_EN
  localparam bit c_PERF_ON = 1'b1;
`else
  localparam bit c_PERF_ON = 1'b0;
`endif

  seq_ctrl #(.RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset), .start(start), .icode(icode),
    .imem_error(imem_error), .func_error(func_error), .halt(halt),
    .valC(valC), .valP(valP), .cnd(cnd), .valM(valM),
    .dmem_error(dmem_error), .PC(PC), .f_en(f_en), .d_en(d_en),
    .e_en(e_en), .m_en(m_en), .w_en(w_en), .stat(stat), .busy(busy),
    .perf_instr(perf_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ic;
    logic        imem, func, hlt, dmem, cd;
    logic [63:0] c, p, m;
  } instr_t;

  typedef struct {
    bit          is_stop;
    logic [63:0] pc;
    logic [2:0]  st;
    logic [31:0] perf;
    int          off;     // cycles since previous fetch; 0 = not checked
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  bit          stp = 1'b0;
  logic [63:0] m_pc = 64'd0;
  logic [31:0] m_perf = 32'd0;
  logic [2:0]  m_stat = 3'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] perf_exp(input logic [31:0] v);
    return c_PERF_ON ? v : 32'd0;
  endfunction

  // ---------------------------------------------------------------- monitor
  bit   running = 1'b0;
  int   cyc = 0;
  exp_t me;

  task automatic score(input bit is_stop);
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      me = sb.pop_front();
      chk("event_kind", 64'(is_stop), 64'(me.is_stop));
      chk("pc", PC, me.pc);
      chk("stat", 64'(stat), 64'(me.st));
      chk("perf_instr", 64'(perf_instr), 64'(me.perf));
      if (me.off != 0) chk("latency", 64'(cyc), 64'(me.off));
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      running = 1'b0;
      cyc     = 0;
    end else begin
      cyc++;
      if (f_en === 1'b1) begin
        score(1'b0);
        running = 1'b1;
        cyc     = 0;
      end else if (running && busy !== 1'b1) begin
        score(1'b1);
        running = 1'b0;
      end
      if (running) begin
        chk("busy_run", 64'(busy), 64'd1);
        chk("enables", 64'({f_en, d_en, e_en, m_en, w_en}), 64'(5'b10000 >> cyc));
      end else begin
        chk("busy_idle", 64'(busy), 64'd0);
        chk("enables_idle", 64'({f_en, d_en, e_en, m_en, w_en}), 64'd0);
      end
    end
  end

  // ---------------------------------------------------------------- driver
  function automatic instr_t mk(input logic [3:0] ic, input logic [63:0] c,
                                input logic [63:0] p, input logic [63:0] m,
                                input logic cd, input logic [3:0] errs);
    instr_t t;
    t.ic = ic; t.c = c; t.p = p; t.m = m; t.cd = cd;
    {t.imem, t.func, t.hlt, t.dmem} = errs;
    return t;
  endfunction

  task automatic wait_fetch(output bit ok);
    int n = 0;
    while (f_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (f_en === 1'b1);
    if (!ok) chk("fetch_wait", 64'(f_en), 64'd1);
  endtask

  task automatic issue(input instr_t in, output bit stopped);
    bit   ok;
    exp_t e;
    wait_fetch(ok);
    if (!ok) begin
      stopped = 1'b1;
      return;
    end
    icode = in.ic; valC = in.c; valP = in.p; valM = in.m; cnd = in.cd;
    imem_error = in.imem; func_error = in.func; halt = in.hlt;
    dmem_error = in.dmem;
    // Architectural outcome of this instruction.
    e.is_stop = 1'b1;
    e.pc      = m_pc;
    e.perf    = perf_exp(m_perf);
    e.off     = 1;
    if (in.imem)      e.st = 3'd3;
    else if (in.func) e.st = 3'd4;
    else if (in.hlt)  e.st = 3'd2;
    else if (in.dmem) begin e.st = 3'd3; e.off = 4; end
    else begin
      if (in.ic == 4'd8)                 m_pc = in.c;
      else if (in.ic == 4'd7 && in.cd)   m_pc = in.c;
      else if (in.ic == 4'd9)            m_pc = in.m;
      else                               m_pc = in.p;
      m_perf    = m_perf + 32'd1;
      e.is_stop = 1'b0;
      e.pc      = m_pc;
      e.st      = 3'd1;
      e.perf    = perf_exp(m_perf);
      e.off     = 6;
    end
    if (e.is_stop) m_stat = e.st;
    stopped = e.is_stop;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic go(input instr_t in);
    bit s;
    if (!stp) begin
      issue(in, s);
      stp = s;
    end
  endtask

  task automatic do_reset;
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pc", PC, 64'd0);
    chk("rst_stat", 64'(stat), 64'd1);
    chk("rst_perf", 64'(perf_instr), 64'd0);
    chk("rst_en", 64'({f_en, d_en, e_en, m_en, w_en}), 64'd0);
    reset = 1'b0;
    sb.delete();
    m_pc = 64'd0; m_perf = 32'd0; m_stat = 3'd1; stp = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic begin_session;
    exp_t e;
    e.is_stop = 1'b0; e.pc = m_pc; e.st = 3'd1; e.perf = perf_exp(m_perf); e.off = 0;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("f_en_after_start", 64'(f_en), 64'd1);
  endtask

  task automatic end_session;
    bit ok;
    if (!stp) begin
      wait_fetch(ok);
      @(negedge clk);
    end else begin
      // Stopped: start must be ignored and PC/stat must stay frozen.
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("stop_busy", 64'(busy), 64'd0);
      chk("stop_pc", PC, m_pc);
      chk("stop_stat", 64'(stat), 64'(m_stat));
    end
    do_reset();
  endtask

  function automatic instr_t rnd_instr();
    instr_t t;
    t.ic   = 4'($urandom_range(0, 11));
    t.c    = {$urandom, $urandom};
    t.p    = {$urandom, $urandom};
    t.m    = {$urandom, $urandom};
    t.cd   = 1'($urandom_range(0, 1));
    t.imem = ($urandom_range(0, 23) == 0);
    t.func = ($urandom_range(0, 23) == 0);
    t.hlt  = ($urandom_range(0, 23) == 0);
    t.dmem = ($urandom_range(0, 23) == 0);
    return t;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    do_reset();

    // nop then observe PC=1 at the second fetch, 6 cycles later
    begin_session(); go(mk(4'd1, 64'd0, 64'd1, 64'd0, 1'b0, 4'b0000)); end_session();

    // jXX taken, then not taken
    begin_session();
    go(mk(4'd7, 64'h100, 64'd9, 64'd0, 1'b1, 4'b0000));
    go(mk(4'd7, 64'h100, 64'd9, 64'd0, 1'b0, 4'b0000));
    end_session();

    // call then ret
    begin_session();
    go(mk(4'd8, 64'h40, 64'd9, 64'd0, 1'b0, 4'b0000));
    go(mk(4'd9, 64'd0, 64'h41, 64'h1D, 1'b0, 4'b0000));
    end_session();

    // halt at PC=0x20
    begin_session();
    go(mk(4'd8, 64'h20, 64'd9, 64'd0, 1'b0, 4'b0000));
    go(mk(4'd0, 64'd0, 64'h21, 64'd0, 1'b0, 4'b0010));
    end_session();

    // imem_error and func_error together: ADR wins
    begin_session(); go(mk(4'd1, 64'd0, 64'd1, 64'd0, 1'b0, 4'b1100)); end_session();
    // func_error alone: INS
    begin_session(); go(mk(4'd1, 64'd0, 64'd1, 64'd0, 1'b0, 4'b0100)); end_session();
    // dmem_error: ADR, no write-back
    begin_session(); go(mk(4'd5, 64'd0, 64'd10, 64'd0, 1'b0, 4'b0001)); end_session();

    // reset in EXECUTE of the instruction at 0x10
    begin_session();
    go(mk(4'd8, 64'h10, 64'd9, 64'd0, 1'b0, 4'b0000));
    go(mk(4'd1, 64'd0, 64'h11, 64'd0, 1'b0, 4'b0000));
    @(negedge clk);
    chk("mid_e_en", 64'(e_en), 64'd1);
    chk("mid_pc", PC, 64'h10);
    do_reset();
    begin_session(); go(mk(4'd1, 64'd0, 64'd4, 64'd0, 1'b0, 4'b0000)); end_session();

    // randomized programs
    for (int s = 0; s < 30; s++) begin
      begin_session();
      for (int i = 0; i < int'($urandom_range(3, 10)); i++) go(rnd_instr());
      end_session();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/seq_ctrl.md
# seq_ctrl

Stage sequencer for the Y86-64 SEQ processor. Steps one instruction at a time through fetch, decode, execute, memory, write-back and PC update, issuing one-cycle enables to each stage. Owns the architectural PC register and the processor status code, and computes the next PC from the stage outputs. Stops the machine on `halt`, invalid instruction or memory error.

## Interface
Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level/pulse; leaves IDLE and begins execution at PC.
- icode  input  4  from fetch.
- imem_error  input  1  from fetch; instruction address invalid.
- func_error  input  1  from fetch; illegal icode/ifun.
- halt  input  1  from fetch; instruction is `halt`.
- valC  input  64  from fetch; constant word / jump target.
- valP  input  64  from fetch; address of next sequential instruction.
- cnd  input  1  from execute; branch condition.
- valM  input  64  from memory; loaded word (return address for `ret`).
- dmem_error  input  1  from memory; data address invalid.
- PC  output  64  current instruction address, drives fetch.
- f_en, d_en, e_en, m_en, w_en  output  1 each  one-hot stage enables.
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- busy  output  1  high in every state except IDLE and STOP.
- perf_instr  output  32  retired-instruction count (see Configuration).

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, STOP.
- IDLE -> FETCH when `start`=1; otherwise hold.
- FETCH: f_en=1. Inputs sampled this cycle, priority imem_error > func_error > halt:
  - imem_error: stat<=ADR, -> STOP.
  - func_error: stat<=INS, -> STOP.
  - halt: stat<=HLT, -> STOP.
  - else -> DECODE.
- DECODE (d_en), EXECUTE (e_en): unconditional advance.
- MEMORY: m_en=1; dmem_error: stat<=ADR, -> STOP (write-back suppressed); else -> WRITEBACK.
- WRITEBACK: w_en=1 -> PCUPD.
- PCUPD: no enables; PC<=new_PC; -> FETCH.
  - icode 8 (call): valC.
  - icode 7 (jXX) and cnd=1: valC.
  - icode 9 (ret): valM.
  - all else: valP.
- STOP: all enables 0, PC and stat frozen; `start` ignored; exit only via reset.
- `start` outside IDLE: ignored.
- Stage enables mutually exclusive; exactly one high in FETCH..WRITEBACK, none elsewhere.

## Timing
- Reset values: state=IDLE, PC=RESET_PC, stat=AOK(1), all enables 0, busy=0, perf_instr=0.
- start sampled high at edge N: f_en high in cycle N+1.
- Instruction latency: 6 cycles (F,D,E,M,W,P); PC visible at new value in the cycle after PCUPD (the next FETCH).
- Error in FETCH at cycle k: stat updated and STOP entered at edge ending cycle k; busy low from cycle k+1.
- reset mid-instruction: next cycle is IDLE with reset values; partial instruction abandoned, PC not updated.
- PC arithmetic: full 64-bit, no wrap check; valP/valC/valM taken verbatim.

## Configuration
- SEQ_PERF_CNT_EN defined: 32-bit retired-instruction counter; increments by 1 at each PCUPD, wraps 0xFFFFFFFF->0, cleared by reset; halting or faulting instruction not counted. Driven on perf_instr.
- Not defined: counter absent, perf_instr tied to 0.

## Test plan
- Reset, start=1 one cycle with fetch reporting nop (icode 1), valP=1: f_en cycles 1 and 7, PC=1 from cycle 7, stat=1, perf_instr=1 (macro on).
- jXX (icode 7), valC=0x100, valP=9: cnd=1 -> PC=0x100; rerun with cnd=0 -> PC=9.
- call (icode 8) valC=0x40 -> PC=0x40; then ret (icode 9) valM=0x1D -> PC=0x1D.
- halt=1 in FETCH at PC=0x20: stat=2, STOP, PC stays 0x20, no d_en, busy=0, later start ignored.
- imem_error and func_error both 1 in FETCH: stat=3 (ADR wins); separately func_error alone -> stat=4; dmem_error in MEMORY -> stat=3, w_en never asserted.
- reset asserted during EXECUTE of instruction at PC=0x10 with RESET_PC=0: next cycle IDLE, PC=0, stat=1, perf_instr=0, all enables 0.
